// File: rtl/fft_addr_gen.sv
// In-place radix-2 FFT address sequencer with valid/ready handshake and inter-stage drain gap.
// Define FFT_DIF_EN for decimation-in-frequency ordering; default build is decimation-in-time.
module fft_addr_gen #(
    parameter int LOG2_NFFT  = 5,
    parameter int BF_LATENCY = 4,
    parameter int STAGE_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bf_ready,
    output logic                 bf_valid,
    output logic [LOG2_NFFT-1:0] addr_a,
    output logic [LOG2_NFFT-1:0] addr_b,
    output logic [LOG2_NFFT-1:0] tw_addr,
    output logic [STAGE_W-1:0]   stage,
    output logic                 busy,
    output logic                 done
);

    localparam int K_W   = LOG2_NFFT - 1;
    localparam int CNT_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

    localparam logic [K_W-1:0]     K_LAST     = {K_W{1'b1}};
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2_NFFT - 1);
    localparam logic [CNT_W-1:0]   DRAIN_INIT = (BF_LATENCY > 0) ? CNT_W'(BF_LATENCY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] drain_cnt;

    logic [LOG2_NFFT-1:0] k_ext;
    logic [LOG2_NFFT-1:0] half;
    logic [LOG2_NFFT-1:0] mask;
    logic [LOG2_NFFT-1:0] j;
    logic [LOG2_NFFT-1:0] g;
    logic [LOG2_NFFT-1:0] dec_a;
    logic [LOG2_NFFT-1:0] dec_b;
    logic [LOG2_NFFT-1:0] dec_tw;
    logic [STAGE_W-1:0]   span_shift;
    logic [STAGE_W-1:0]   tw_shift;

    // Butterfly span grows with stage for DIT and shrinks with stage for DIF.
    always_comb begin
        k_ext = {1'b0, k};
`ifdef FFT_DIF_EN
        span_shift = LAST_STAGE - stage;
        tw_shift   = stage;
`else
        span_shift = stage;
        tw_shift   = LAST_STAGE - stage;
`endif
        half   = LOG2_NFFT'(1) << span_shift;
        mask   = half - LOG2_NFFT'(1);
        j      = k_ext & mask;
        g      = k_ext >> span_shift;
        dec_a  = ((g << span_shift) << 1) | j;
        dec_b  = dec_a + half;
        dec_tw = j << tw_shift;
    end

    // Addresses read as zero whenever no address set is being offered.
    assign addr_a  = bf_valid ? dec_a  : '0;
    assign addr_b  = bf_valid ? dec_b  : '0;
    assign tw_addr = bf_valid ? dec_tw : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            bf_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        stage    <= '0;
                        k        <= '0;
                        bf_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (bf_ready) begin
                        if (k != K_LAST) begin
                            k <= k + 1'b1;
                        end else begin
                            k <= '0;
                            if (BF_LATENCY > 0) begin
                                state     <= DRAIN;
                                drain_cnt <= DRAIN_INIT;
                                bf_valid  <= 1'b0;
                            end else if (stage == LAST_STAGE) begin
                                state    <= DONE;
                                stage    <= '0;
                                bf_valid <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                stage <= stage + STAGE_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else if (stage == LAST_STAGE) begin
                        state <= DONE;
                        stage <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= RUN;
                        stage    <= stage + STAGE_W'(1);
                        bf_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bf_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
